// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the 8259A-style interrupt sequencer.
package pic_pkg;

  // Request line count; the priority logic is written for exactly 8 lines.
  localparam int NUM_IRQ = 8;
  localparam int LEVEL_W = 3;

  typedef logic [LEVEL_W-1:0] level_t;

  // Level reported when the request disappears before the first INTA.
  localparam level_t SPURIOUS_LEVEL_DEFAULT = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    ACK1,
    ACK2
  } state_t;

  // Vector presented on the second INTA: base in [7:3], level in [2:0].
  typedef struct packed {
    logic [4:0] base;
    level_t     level;
  } vector_t;

  // Priority rank of a level relative to the current lowest-priority level.
  // Rank 0 is the highest priority (the level just after lowestPriority).
  function automatic level_t priority_rank(level_t level, level_t lowest);
    return level_t'(level - lowest - 3'd1);
  endfunction

  function automatic logic [NUM_IRQ-1:0] level_onehot(level_t level);
    return NUM_IRQ'(1) << level;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Request/acknowledge/EOI bundle between the PIC front end and the sequencer.
interface interrupt_sequencer_if;
  import pic_pkg::*;

  logic [NUM_IRQ-1:0] interruptRequest;
  logic [NUM_IRQ-1:0] interruptMask;
  logic               inta;
  logic               eoiValid;
  logic               eoiSpecific;
  level_t             eoiLevel;
  logic               rotateOnEoi;
  logic               autoEoi;
  logic [4:0]         vectorBase;

  logic               intOut;
  logic [NUM_IRQ-1:0] clearInterruptRequest;
  logic [NUM_IRQ-1:0] inServiceReg;
  vector_t            vectorOut;
  logic               vectorValid;

  // Side that drives requests, acknowledges and commands.
  modport master (
    output interruptRequest, interruptMask, inta, eoiValid, eoiSpecific,
           eoiLevel, rotateOnEoi, autoEoi, vectorBase,
    input  intOut, clearInterruptRequest, inServiceReg, vectorOut, vectorValid
  );

  // The sequencer itself.
  modport slave (
    input  interruptRequest, interruptMask, inta, eoiValid, eoiSpecific,
           eoiLevel, rotateOnEoi, autoEoi, vectorBase,
    output intOut, clearInterruptRequest, inServiceReg, vectorOut, vectorValid
  );

endinterface

// File: rtl/interrupt_sequencer_priority_resolver.sv
// Rotating find-first: returns the highest-priority set bit, searching
// upward from lowestPriority+1 and wrapping modulo 8.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] request,
  input  level_t             lowestPriority,
  output logic               valid,
  output level_t             level
);

  logic [NUM_IRQ-1:0] rotated;
  level_t             start;
  level_t             offset;

  assign start = level_t'(lowestPriority + 3'd1);

  // Rotate so that bit 0 of 'rotated' is the highest-priority request line.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_rot
      assign rotated[gi] = request[level_t'(start + level_t'(gi))];
    end
  endgenerate

  // Find the lowest set bit of the rotated vector.
  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        valid  = 1'b1;
        offset = level_t'(i);
      end
    end
  end

  assign level = level_t'(start + offset);

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: priority resolution against the ISR, INT generation,
// two-pulse INTA acknowledge, ISR maintenance and EOI handling.
module interrupt_sequencer
  import pic_pkg::*;
#(
  parameter level_t SPURIOUS_LEVEL = SPURIOUS_LEVEL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  interrupt_sequencer_if.slave  bus
);

  state_t             state_reg;
  logic               int_out_reg;
  logic [NUM_IRQ-1:0] clear_reg;
  logic [NUM_IRQ-1:0] isr_reg;
  level_t             lowest_reg;
  level_t             latched_level_reg;
  logic               spurious_reg;
  vector_t            vector_reg;
  logic               vector_valid_reg;
  logic               inta_prev_reg;

  logic [NUM_IRQ-1:0] eligible;
  logic               win_valid;
  level_t             win_level;
  logic               isr_valid;
  level_t             isr_level;
  logic               qualify;
  logic               inta_edge;

  logic [NUM_IRQ-1:0] eoi_clear_mask;
  logic               eoi_rotate;
  level_t             eoi_level;
  logic [NUM_IRQ-1:0] isr_next;
  level_t             lowest_next;

  assign eligible  = bus.interruptRequest & ~bus.interruptMask;
  assign inta_edge = bus.inta & ~inta_prev_reg;

  priority_resolver u_req_resolver (
    .request        (eligible),
    .lowestPriority (lowest_reg),
    .valid          (win_valid),
    .level          (win_level)
  );

  priority_resolver u_isr_resolver (
    .request        (isr_reg),
    .lowestPriority (lowest_reg),
    .valid          (isr_valid),
    .level          (isr_level)
  );

  // A winner only interrupts if it outranks everything already in service.
  assign qualify = win_valid &&
                   (!isr_valid ||
                    (priority_rank(win_level, lowest_reg) <
                     priority_rank(isr_level, lowest_reg)));

  // Decode the EOI command into a clear mask and optional new lowest level.
  always_comb begin
    eoi_clear_mask = '0;
    eoi_rotate     = 1'b0;
    eoi_level      = bus.eoiLevel;
    if (bus.eoiValid) begin
      if (bus.eoiSpecific) begin
        if (isr_reg[bus.eoiLevel]) begin
          eoi_clear_mask = level_onehot(bus.eoiLevel);
          eoi_rotate     = bus.rotateOnEoi;
        end
      end else if (isr_valid) begin
        eoi_level      = isr_level;
        eoi_clear_mask = level_onehot(isr_level);
        eoi_rotate     = bus.rotateOnEoi;
      end
    end
  end

  assign isr_next    = isr_reg & ~eoi_clear_mask;
  assign lowest_next = eoi_rotate ? eoi_level : lowest_reg;

  // Acknowledge FSM with registered outputs; EOI is applied every cycle and
  // the ACK1 set / auto-EOI clear are layered on top of the post-EOI ISR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      int_out_reg       <= 1'b0;
      clear_reg         <= '0;
      isr_reg           <= '0;
      lowest_reg        <= 3'd7;
      latched_level_reg <= '0;
      spurious_reg      <= 1'b0;
      vector_reg        <= '0;
      vector_valid_reg  <= 1'b0;
      inta_prev_reg     <= 1'b0;
    end else begin
      inta_prev_reg    <= bus.inta;
      clear_reg        <= '0;
      vector_valid_reg <= 1'b0;
      isr_reg          <= isr_next;
      lowest_reg       <= lowest_next;

      case (state_reg)
        IDLE: begin
          if (qualify) begin
            state_reg   <= PENDING;
            int_out_reg <= 1'b1;
          end
        end

        PENDING: begin
          if (inta_edge) begin
            state_reg   <= ACK1;
            int_out_reg <= 1'b0;
            if (win_valid) begin
              latched_level_reg <= win_level;
              spurious_reg      <= 1'b0;
              isr_reg           <= isr_next | level_onehot(win_level);
              clear_reg         <= level_onehot(win_level);
            end else begin
              latched_level_reg <= SPURIOUS_LEVEL;
              spurious_reg      <= 1'b1;
            end
          end else if (!qualify) begin
            state_reg   <= IDLE;
            int_out_reg <= 1'b0;
          end
        end

        ACK1: begin
          if (inta_edge) begin
            state_reg        <= ACK2;
            vector_reg       <= '{base: bus.vectorBase, level: latched_level_reg};
            vector_valid_reg <= 1'b1;
            if (bus.autoEoi && !spurious_reg) begin
              isr_reg <= isr_next & ~level_onehot(latched_level_reg);
              if (bus.rotateOnEoi) begin
                lowest_reg <= latched_level_reg;
              end
            end
          end
        end

        ACK2: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.intOut                = int_out_reg;
  assign bus.clearInterruptRequest = clear_reg;
  assign bus.inServiceReg          = isr_reg;
  assign bus.vectorOut             = vector_reg;
  assign bus.vectorValid           = vector_valid_reg;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: directed sequences push expected
// clear pulses and vectors; a monitor pops and compares them as they appear.
module tb_interrupt_sequencer;
  import pic_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] vec_q[$];
  logic [7:0] clr_q[$];
  logic [7:0] mon_vec_exp;
  logic [7:0] mon_clr_exp;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%02h", name, act);
    end
  endtask

  // Monitor: every clear pulse and every vector must match the queue head.
  always @(negedge clk) begin
    if (bus.vectorValid === 1'b1) begin
      if (vec_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL vector: got unexpected 0x%02h, expected none", bus.vectorOut);
      end else begin
        mon_vec_exp = vec_q.pop_front();
        check("vector", bus.vectorOut, mon_vec_exp);
      end
    end
    if (bus.clearInterruptRequest !== 8'h00) begin
      if (clr_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL clear: got unexpected 0x%02h, expected none", bus.clearInterruptRequest);
      end else begin
        mon_clr_exp = clr_q.pop_front();
        check("clear", bus.clearInterruptRequest, mon_clr_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two INTA pulses; the IRR value after the clear pulse is req_after.
  task automatic ack(input string name, input logic [7:0] req_after,
                     input logic [7:0] isr_ack1, input logic [7:0] isr_ack2);
    bus.inta = 1'b1;
    tick();
    check({name, " isr@ack1"}, bus.inServiceReg, isr_ack1);
    check({name, " intOut@ack1"}, {7'd0, bus.intOut}, 8'h00);
    bus.interruptRequest = req_after;
    bus.inta = 1'b0;
    tick();
    bus.inta = 1'b1;
    tick();
    bus.inta = 1'b0;
    check({name, " isr@ack2"}, bus.inServiceReg, isr_ack2);
    tick();
  endtask

  task automatic eoi(input logic specific, input level_t level, input logic rotate);
    bus.eoiSpecific = specific;
    bus.eoiLevel    = level;
    bus.rotateOnEoi = rotate;
    bus.eoiValid    = 1'b1;
    tick();
    bus.eoiValid    = 1'b0;
    bus.eoiSpecific = 1'b0;
    bus.rotateOnEoi = 1'b0;
  endtask

  initial begin
    bus.interruptRequest = '0;
    bus.interruptMask    = '0;
    bus.inta             = 1'b0;
    bus.eoiValid         = 1'b0;
    bus.eoiSpecific      = 1'b0;
    bus.eoiLevel         = '0;
    bus.rotateOnEoi      = 1'b0;
    bus.autoEoi          = 1'b0;
    bus.vectorBase       = 5'd1;

    // Reset state
    repeat (2) tick();
    check("reset intOut", {7'd0, bus.intOut}, 8'h00);
    check("reset clear", bus.clearInterruptRequest, 8'h00);
    check("reset isr", bus.inServiceReg, 8'h00);
    check("reset vectorOut", bus.vectorOut, 8'h00);
    check("reset vectorValid", {7'd0, bus.vectorValid}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Fixed priority: 0x24 -> IR2 wins
    bus.interruptRequest = 8'h24;
    clr_q.push_back(8'h04);
    vec_q.push_back(8'h0A);
    tick();
    check("fixed intOut", {7'd0, bus.intOut}, 8'h01);
    ack("fixed", 8'h20, 8'h04, 8'h04);

    // Nesting: IR5 is below in-service IR2, IR1 is above it
    tick();
    check("nest IR5 blocked", {7'd0, bus.intOut}, 8'h00);
    bus.interruptRequest = 8'h22;
    clr_q.push_back(8'h02);
    vec_q.push_back(8'h09);
    tick();
    check("nest IR1 intOut", {7'd0, bus.intOut}, 8'h01);
    ack("nest", 8'h20, 8'h06, 8'h06);
    bus.interruptRequest = 8'h00;
    eoi(1'b0, 3'd0, 1'b0);
    check("nonspec eoi 1", bus.inServiceReg, 8'h04);
    eoi(1'b0, 3'd0, 1'b0);
    check("nonspec eoi 2", bus.inServiceReg, 8'h00);

    // Spurious: IR3 vanishes together with the first INTA edge
    bus.interruptRequest = 8'h08;
    vec_q.push_back(8'h0F);
    tick();
    check("spur intOut", {7'd0, bus.intOut}, 8'h01);
    bus.interruptRequest = 8'h00;
    ack("spur", 8'h00, 8'h00, 8'h00);

    // Rotation: service IR4, specific EOI 4 with rotate, then 0x21 -> IR5
    bus.interruptRequest = 8'h10;
    clr_q.push_back(8'h10);
    vec_q.push_back(8'h0C);
    tick();
    check("rot IR4 intOut", {7'd0, bus.intOut}, 8'h01);
    ack("rot IR4", 8'h00, 8'h10, 8'h10);
    eoi(1'b1, 3'd4, 1'b1);
    check("spec eoi rotate", bus.inServiceReg, 8'h00);
    bus.interruptRequest = 8'h21;
    clr_q.push_back(8'h20);
    vec_q.push_back(8'h0D);
    tick();
    check("rot IR5 intOut", {7'd0, bus.intOut}, 8'h01);
    ack("rot IR5", 8'h01, 8'h20, 8'h20);
    tick();
    check("rot IR0 below IR5", {7'd0, bus.intOut}, 8'h00);
    bus.interruptRequest = 8'h00;
    eoi(1'b0, 3'd0, 1'b0);
    check("rot eoi IR5", bus.inServiceReg, 8'h00);

    // Auto-EOI on IR6
    bus.autoEoi = 1'b1;
    bus.interruptRequest = 8'h40;
    clr_q.push_back(8'h40);
    vec_q.push_back(8'h0E);
    tick();
    check("aeoi intOut", {7'd0, bus.intOut}, 8'h01);
    ack("aeoi", 8'h00, 8'h40, 8'h00);
    bus.autoEoi = 1'b0;

    // Reset between the two INTA pulses
    bus.interruptRequest = 8'h08;
    clr_q.push_back(8'h08);
    tick();
    check("rst intOut", {7'd0, bus.intOut}, 8'h01);
    bus.inta = 1'b1;
    tick();
    check("rst isr@ack1", bus.inServiceReg, 8'h08);
    bus.interruptRequest = 8'h00;
    bus.inta = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midack intOut", {7'd0, bus.intOut}, 8'h00);
    check("midack clear", bus.clearInterruptRequest, 8'h00);
    check("midack isr", bus.inServiceReg, 8'h00);
    check("midack vectorOut", bus.vectorOut, 8'h00);
    check("midack vectorValid", {7'd0, bus.vectorValid}, 8'h00);
    bus.inta = 1'b1;
    tick();
    tick();
    bus.inta = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check("post-rst vectorValid", {7'd0, bus.vectorValid}, 8'h00);

    // Fresh sequence after reset: IR0 with default priority
    bus.interruptRequest = 8'h01;
    clr_q.push_back(8'h01);
    vec_q.push_back(8'h08);
    tick();
    check("fresh intOut", {7'd0, bus.intOut}, 8'h01);
    ack("fresh", 8'h00, 8'h01, 8'h01);
    repeat (3) tick();

    check("vectors outstanding", 8'(vec_q.size()), 8'h00);
    check("clears outstanding", 8'(clr_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
